// File: rtl/pc_ctrl_pkg.sv
// Shared types and default sizes for the program-counter sequencing controller.
package pc_ctrl_pkg;

    localparam int unsigned DefD  = 8;
    localparam int unsigned DefLw = 4;
    localparam int unsigned DefSd = 4;

    typedef enum logic [2:0] {
        OpNone = 3'd0,
        OpJmp  = 3'd1,
        OpBz   = 3'd2,
        OpBnz  = 3'd3,
        OpCall = 3'd4,
        OpRet  = 3'd5,
        OpHalt = 3'd6,
        OpRsvd = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } state_t;

endpackage

// File: rtl/ret_stack.sv
// Hardware return-address stack: LIFO of SD entries with full/empty flags and sync clear.
module ret_stack
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned D  = DefD,
    parameter int unsigned SD = DefSd
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  logic [D-1:0] push_data,
    output logic [D-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PW = $clog2(SD + 1);
    localparam int unsigned IW = (SD > 1) ? $clog2(SD) : 1;

    logic [D-1:0]  mem_q [SD];
    logic [PW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] top_pos;
    logic          do_push;

    assign full    = (cnt_q == PW'(SD));
    assign empty   = (cnt_q == '0);
    assign top_pos = cnt_q - PW'(1);
    assign top     = empty ? '0 : mem_q[top_pos[IW-1:0]];
    assign do_push = push && !full && !clear;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (push && !full) begin
            cnt_d = cnt_q + PW'(1);
        end else if (pop && !empty) begin
            cnt_d = cnt_q - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Entry contents need no reset; they are only visible below the count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[cnt_q[IW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/pc_ctrl.sv
// PC sequencing controller: start/halt FSM, branch target LUT, call/return stack.
// branch/target are combinational so the PC loads on the very next edge.
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned D  = DefD,
    parameter int unsigned LW = DefLw,
    parameter int unsigned SD = DefSd
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [D-1:0]  prog_ctr,
    input  logic [2:0]    op,
    input  logic [LW-1:0] lut_idx,
    input  logic          zero,
    input  logic          lut_we,
    input  logic [LW-1:0] lut_waddr,
    input  logic [D-1:0]  lut_wdata,
    output logic          branch,
    output logic [D-1:0]  target,
    output logic          running,
    output logic          done,
    output logic          err
);

    localparam int unsigned NL = 1 << LW;

    state_t       state_q, state_d;
    logic         err_q, err_d;
    logic [D-1:0] lut_q [NL];
    logic [D-1:0] lut_val;
    logic [D-1:0] ret_addr;
    logic [D-1:0] stk_top;
    logic         stk_push, stk_pop, stk_clear, stk_full, stk_empty;
    op_t          op_dec;

    assign op_dec   = op_t'(op);
    assign lut_val  = lut_q[lut_idx];
    assign ret_addr = prog_ctr + D'(1);

    ret_stack #(
        .D  (D),
        .SD (SD)
    ) u_ret_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (stk_push),
        .pop       (stk_pop),
        .clear     (stk_clear),
        .push_data (ret_addr),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        branch    = 1'b0;
        target    = prog_ctr;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_clear = 1'b0;
        case (state_q)
            StIdle: begin
                branch = 1'b1;
                if (start) begin
                    target  = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                case (op_dec)
                    OpJmp: begin
                        branch = 1'b1;
                        target = lut_val;
                    end
                    OpBz: begin
                        if (zero) begin
                            branch = 1'b1;
                            target = prog_ctr + lut_val;
                        end
                    end
                    OpBnz: begin
                        if (!zero) begin
                            branch = 1'b1;
                            target = prog_ctr + lut_val;
                        end
                    end
                    OpCall: begin
                        // Overflow drops the return address but still takes the jump.
                        branch = 1'b1;
                        target = lut_val;
                        if (stk_full) begin
                            err_d = 1'b1;
                        end else begin
                            stk_push = 1'b1;
                        end
                    end
                    OpRet: begin
                        branch = 1'b1;
                        if (stk_empty) begin
                            err_d   = 1'b1;
                            state_d = StHalt;
                        end else begin
                            stk_pop = 1'b1;
                            target  = stk_top;
                        end
                    end
                    OpHalt: begin
                        branch  = 1'b1;
                        state_d = StHalt;
                    end
                    default: ;
                endcase
            end
            StHalt: begin
                branch = 1'b1;
                if (start) begin
                    target    = '0;
                    state_d   = StRun;
                    stk_clear = 1'b1;
                    err_d     = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NL); i++) begin
                lut_q[i] <= '0;
            end
        end else if (lut_we) begin
            lut_q[lut_waddr] <= lut_wdata;
        end
    end

    assign running = (state_q == StRun);
    assign done    = (state_q == StHalt);
    assign err     = err_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed vectors, corner sequences and a random run
// against a queue-based behavioural model.
module tb_pc_ctrl;
    import pc_ctrl_pkg::*;

    localparam int unsigned D  = 8;
    localparam int unsigned LW = 4;
    localparam int unsigned SD = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

    logic          clk = 1'b0;
    logic          reset, start, zero, lut_we;
    logic [D-1:0]  prog_ctr, lut_wdata, target;
    logic [2:0]    op;
    logic [LW-1:0] lut_idx, lut_waddr;
    logic          branch, running, done, err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]    op;
        logic [LW-1:0] idx;
        logic          z;
        logic [D-1:0]  pc;
        logic          eb;
        logic [D-1:0]  et;
    } vec_t;

    vec_t vecs[10];

    // Behavioural model state
    int           mode;
    logic [D-1:0] mlut [16];
    logic [D-1:0] stk[$];
    logic         merr;
    logic [D-1:0] mpc;

    pc_ctrl #(
        .D  (D),
        .LW (LW),
        .SD (SD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .prog_ctr  (prog_ctr),
        .op        (op),
        .lut_idx   (lut_idx),
        .zero      (zero),
        .lut_we    (lut_we),
        .lut_waddr (lut_waddr),
        .lut_wdata (lut_wdata),
        .branch    (branch),
        .target    (target),
        .running   (running),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Emulates the PC register: loads target on branch, else increments.
    task automatic advance();
        logic [D-1:0] nxt;
        #1;
        nxt = branch ? target : prog_ctr + 8'd1;
        @(negedge clk);
        prog_ctr = nxt;
    endtask

    task automatic lut_write(input logic [LW-1:0] a, input logic [D-1:0] d);
        lut_we    = 1'b1;
        lut_waddr = a;
        lut_wdata = d;
        @(negedge clk);
        lut_we = 1'b0;
    endtask

    task automatic model_reset();
        mode = M_IDLE;
        stk.delete();
        merr = 1'b0;
        for (int i = 0; i < 16; i++) mlut[i] = '0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = OpNone; lut_idx = '0; zero = 1'b0;
        lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0; prog_ctr = 8'h33;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_running", running, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("idle_branch", branch, 1);
        check("idle_target", target, 8'h33);

        // LUT writes are accepted while idle
        @(negedge clk);
        lut_write(4'd1, 8'h40);
        lut_write(4'd2, 8'hFC);
        lut_write(4'd3, 8'h05);
        lut_write(4'd4, 8'h20);

        start = 1'b1;
        #1;
        check("start_target", target, 0);
        check("start_branch", branch, 1);
        advance();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            op = OpNone;
            #1;
            check("run_pc", prog_ctr, i);
            check("run_branch", branch, 0);
            check("run_running", running, 1);
            check("run_done", done, 0);
            check("run_err", err, 0);
            advance();
        end

        vecs[0] = '{OpNone, 4'd0, 1'b0, 8'h20, 1'b0, 8'h00};
        vecs[1] = '{OpJmp,  4'd1, 1'b0, 8'h20, 1'b1, 8'h40};
        vecs[2] = '{OpBz,   4'd2, 1'b1, 8'd10, 1'b1, 8'd6};
        vecs[3] = '{OpBz,   4'd2, 1'b0, 8'd10, 1'b0, 8'h00};
        vecs[4] = '{OpBnz,  4'd3, 1'b0, 8'hFE, 1'b1, 8'h03};
        vecs[5] = '{OpBnz,  4'd3, 1'b1, 8'hFE, 1'b0, 8'h00};
        vecs[6] = '{OpRsvd, 4'd1, 1'b0, 8'h55, 1'b0, 8'h00};
        vecs[7] = '{OpJmp,  4'd0, 1'b0, 8'h55, 1'b1, 8'h00};
        vecs[8] = '{OpBz,   4'd4, 1'b1, 8'hF0, 1'b1, 8'h10};
        vecs[9] = '{OpCall, 4'd1, 1'b0, 8'h10, 1'b1, 8'h40};
        foreach (vecs[i]) begin
            @(negedge clk);
            op = vecs[i].op; lut_idx = vecs[i].idx; zero = vecs[i].z; prog_ctr = vecs[i].pc;
            #1;
            check("vec_branch", branch, vecs[i].eb);
            if (vecs[i].eb) check("vec_target", target, vecs[i].et);
            #1;
            op = OpNone;
        end

        // CALL then RET
        @(negedge clk);
        prog_ctr = 8'h10; op = OpCall; lut_idx = 4'd1;
        #1;
        check("call_target", target, 8'h40);
        advance();
        check("call_pc", prog_ctr, 8'h40);
        prog_ctr = 8'h45; op = OpRet;
        #1;
        check("ret_branch", branch, 1);
        check("ret_target", target, 8'h11);
        advance();
        op = OpNone;
        #1;
        check("ret_err", err, 0);

        // Five nested calls overflow a 4-deep stack
        for (int k = 0; k < 5; k++) begin
            op = OpCall; lut_idx = 4'd1;
            #1;
            check("nest_branch", branch, 1);
            check("nest_target", target, 8'h40);
            advance();
            #1;
            check("nest_err", err, (k == 4) ? 1 : 0);
        end

        // HALT at PC 7 freezes the PC
        prog_ctr = 8'd7; op = OpHalt;
        #1;
        check("halt_target", target, 8'd7);
        advance();
        op = OpNone;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("halt_pc", prog_ctr, 8'd7);
            check("halt_done", done, 1);
            check("halt_running", running, 0);
            advance();
        end
        start = 1'b1;
        #1;
        check("restart_target", target, 0);
        advance();
        start = 1'b0;
        #1;
        check("restart_pc", prog_ctr, 0);
        check("restart_done", done, 0);
        check("restart_err", err, 0);
        check("restart_running", running, 1);

        // RET on the now-empty stack
        prog_ctr = 8'h21; op = OpRet;
        #1;
        check("uflow_branch", branch, 1);
        check("uflow_target", target, 8'h21);
        advance();
        op = OpNone;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("uflow_err", err, 1);
            check("uflow_done", done, 1);
            check("uflow_pc", prog_ctr, 8'h21);
            advance();
        end

        // Same-cycle LUT write and read returns the old entry
        start = 1'b1;
        advance();
        start = 1'b0;
        op = OpJmp; lut_idx = 4'd4; lut_we = 1'b1; lut_waddr = 4'd4; lut_wdata = 8'h30;
        #1;
        check("lut_old", target, 8'h20);
        advance();
        lut_we = 1'b0;
        #1;
        check("lut_new", target, 8'h30);
        advance();

        // Reset with start mid-run
        op = OpNone; reset = 1'b1; start = 1'b1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        #1;
        check("mrst_running", running, 0);
        check("mrst_done", done, 0);
        check("mrst_err", err, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mrst_branch", branch, 1);
            check("mrst_pc", prog_ctr, 8'h30);
            advance();
        end
        start = 1'b1;
        advance();
        start = 1'b0; op = OpJmp; lut_idx = 4'd4;
        #1;
        check("mrst_lut", target, 8'h00);
        advance();

        // Randomised run against the behavioural model
        op = OpNone; reset = 1'b1;
        @(negedge clk);
        model_reset();
        reset = 1'b0;
        mpc = 8'($urandom);
        for (int n = 0; n < 800; n++) begin
            logic         r_rst, eb;
            logic [D-1:0] et, entry;
            int           nmode, sel;
            r_rst = ($urandom_range(0, 99) == 0);
            sel   = $urandom_range(0, 15);
            case (sel)
                0, 1, 2:    op = OpNone;
                3, 4:       op = OpJmp;
                5, 6:       op = OpBz;
                7, 8:       op = OpBnz;
                9, 10, 11:  op = OpCall;
                12, 13, 14: op = OpRet;
                default:    op = ($urandom_range(0, 1) == 0) ? OpHalt : OpRsvd;
            endcase
            start     = ($urandom_range(0, 3) == 0);
            zero      = 1'($urandom);
            lut_idx   = 4'($urandom_range(0, 7));
            lut_we    = ($urandom_range(0, 2) == 0);
            lut_waddr = 4'($urandom_range(0, 7));
            lut_wdata = 8'($urandom);
            reset     = r_rst;
            prog_ctr  = mpc;
            #1;

            entry = mlut[lut_idx];
            eb = 1'b0; et = mpc; nmode = mode;
            if (mode != M_RUN) begin
                eb = 1'b1;
                if (start) begin
                    et = '0;
                    nmode = M_RUN;
                end
            end else begin
                if (op == OpJmp) begin
                    eb = 1'b1; et = entry;
                end else if ((op == OpBz && zero) || (op == OpBnz && !zero)) begin
                    eb = 1'b1; et = mpc + entry;
                end else if (op == OpCall) begin
                    eb = 1'b1; et = entry;
                end else if (op == OpRet) begin
                    eb = 1'b1;
                    if (stk.size() == 0) nmode = M_HALT;
                    else et = stk[$];
                end else if (op == OpHalt) begin
                    eb = 1'b1; nmode = M_HALT;
                end
            end

            check("rnd_running", running, (mode == M_RUN) ? 1 : 0);
            check("rnd_done", done, (mode == M_HALT) ? 1 : 0);
            check("rnd_err", err, merr);
            if (!r_rst) begin
                check("rnd_branch", branch, eb);
                if (eb) check("rnd_target", target, et);
            end

            if (r_rst) begin
                model_reset();
            end else begin
                if (mode == M_HALT && start) begin
                    stk.delete();
                    merr = 1'b0;
                end
                if (mode == M_RUN && op == OpCall) begin
                    if (stk.size() == SD) merr = 1'b1;
                    else stk.push_back(mpc + 8'd1);
                end
                if (mode == M_RUN && op == OpRet) begin
                    if (stk.size() == 0) merr = 1'b1;
                    else void'(stk.pop_back());
                end
                if (lut_we) mlut[lut_waddr] = lut_wdata;
                mode = nmode;
                mpc  = eb ? et : mpc + 8'd1;
            end
            @(negedge clk);
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Sequencing controller for the program counter. Each cycle it decodes the current control op from the instruction decoder, resolves absolute and relative branch targets through a small programmable target lookup table (LUT), and maintains a hardware return-address stack for call/return. It also runs the start/halt state machine, freezing the PC while idle or halted. Its `branch` and `target` outputs drive the PC directly; it reads `prog_ctr` back.

## Interface

Parameters:

- `D`, 8, PC and target width.
- `LW`, 4, LUT index width (2^LW entries).
- `SD`, 4, return-stack depth.

Ports:

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `start`  in  1  begin or restart execution at PC 0
- `prog_ctr`  in  D  current PC value
- `op`  in  3  decoded control op
- `lut_idx`  in  LW  LUT entry used by JMP/BZ/BNZ/CALL
- `zero`  in  1  ALU zero flag for the current instruction
- `lut_we`  in  1  LUT write enable
- `lut_waddr`  in  LW  LUT write address
- `lut_wdata`  in  D  LUT write data
- `branch`  out  1  PC load strobe
- `target`  out  D  PC load value
- `running`  out  1  high only in RUN; gates datapath writes
- `done`  out  1  high in HALT
- `err`  out  1  sticky stack overflow or underflow

## Operation

- Ops:
  - 0 NONE.
  - 1 JMP: absolute jump to LUT[idx].
  - 2 BZ: relative, taken if `zero`.
  - 3 BNZ: relative, taken if `!zero`.
  - 4 CALL: push `prog_ctr+1`, then absolute jump to LUT[idx].
  - 5 RET: pop, jump to the popped value.
  - 6 HALT.
  - 7 reserved, treated as NONE.
- Relative target = `prog_ctr` + LUT[idx], where the LUT entry is a two's-complement value. The sum is taken modulo 2^D (wraps). Absolute targets are used as stored.
- States and outputs:
  - IDLE: `branch`=1, `target`=`prog_ctr` (PC frozen). On `start`: `target`=0, next state RUN.
  - RUN: `branch`/`target` decoded from `op`. When not taken, `branch`=0 (PC increments). HALT op → HALT with `branch`=1, `target`=`prog_ctr`. `start` is ignored in RUN.
  - HALT: PC frozen as in IDLE, `done`=1. On `start`: `target`=0, stack cleared, `err` cleared, next state RUN.
- Return stack:
  - CALL when full: `err` set, push dropped, jump still taken.
  - RET when empty: `err` set, `branch`=1, `target`=`prog_ctr`, next state HALT.
  - Stack pointer changes only in RUN.
- LUT:
  - Write is registered.
  - A same-cycle read of the entry being written returns the old value.
  - Writes are accepted in every state.
- Reset:
  - State IDLE, stack empty, all LUT entries 0.
  - Output values under reset: `running`=0, `done`=0, `err`=0.
  - Reset during RUN or HALT has the same effect and overrides `start`.

## Timing

- `branch` and `target` are combinational from state, `op`, `zero`, the LUT and the stack top. The PC takes the new value at the next edge, so there is zero added latency and no bubble.
- State, stack, LUT and `err` update on `posedge clk`.
- `running`, `done` and `err` are derived from registered state only (glitch-free).
- `start` is sampled at the clock edge. RUN is entered on the edge after `start`, at which point the PC is 0.
- CALL and RET are both single-cycle: push or pop and the jump happen on the same edge.

## Structure

- Package `pc_ctrl_pkg`:
  - `op_t` enum (NONE … RSVD).
  - `state_t` enum (IDLE, RUN, HALT).
  - Default parameter constants.
- Sub-module `ret_stack`:
  - Parameterised by D and SD.
  - Ports: push, pop, clear, push data, top, full, empty.
  - Synchronous clear.
- `pc_ctrl` holds the FSM, the LUT register array and the target mux.

## Test plan

- Reset, then `start`, then 5 cycles of NONE → `branch`=0, `running`=1, PC sequence 0,1,2,3,4; `done`=0, `err`=0.
- LUT[2]=0xFC (−4); BZ idx 2 at PC 10 with `zero`=1 → `target`=6. Same case with `zero`=0 → `branch`=0. BNZ with LUT[3]=0x05 at PC 0xFE → `target`=0x03 (wrap).
- LUT[1]=0x40; CALL at PC 0x10 → `target`=0x40. After RET at PC 0x45 → `target`=0x11.
- Five nested CALLs with SD=4 → `err`=1 after the 5th, jump still taken. RET on an empty stack → `err`=1, HALT, PC frozen.
- HALT at PC 7 → PC stays 7 and `done`=1 for 10 cycles. Then `start` → PC 0, `done`=0, `err`=0, stack empty.
- Same-cycle write and JMP on LUT[4] (old 0x20, new 0x30) → `target`=0x20, and the next JMP → 0x30. Reset asserted mid-RUN together with `start` → IDLE, PC frozen.
